button_ctrl: RTL and testbench

BUTTON_CTRL -- requirements
Module: button_ctrl

---
 rtl/button_ctrl.sv | 111 +++++++++++
 tb/tb_button_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : button_ctrl
// Brief   : Debounced enable/direction push-button toggles plus count strobe
// Revision: 1.0
// ============================================================================
module button_ctrl #(
  parameter int unsigned DB_CYCLES   = 65536,
  parameter int unsigned TICK_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic dir,
  output logic en_pulse,
  output logic dir_pulse,
  output logic en_state,
  output logic dir_state,
  output logic count_tick
);

  localparam int unsigned      CNT_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [31:0]      TICK_LAST = 32'(TICK_CYCLES - 1);

  logic [1:0]  btn_raw;
  logic [1:0]  pulse_w;
  logic        en_state_q, en_state_d;
  logic        dir_state_q, dir_state_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic        tick_q, tick_d;

  assign btn_raw = {dir, en};

  // Channel 0 is en, channel 1 is dir; both are identical and independent.
  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic             sync1_q, sync2_q;
    logic             db_q, db_d, db_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q;

    always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
        if (cnt_q == DB_LAST) begin
          db_d = ~db_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        db_q     <= 1'b0;
        db_dly_q <= 1'b0;
        cnt_q    <= '0;
        pulse_q  <= 1'b0;
      end else begin
        sync1_q  <= btn_raw[g];
        sync2_q  <= sync1_q;
        db_q     <= db_d;
        db_dly_q <= db_q;
        cnt_q    <= cnt_d;
        pulse_q  <= db_q & ~db_dly_q;
      end
    end

    assign pulse_w[g] = pulse_q;
  end

  always_comb begin
    en_state_d  = en_state_q ^ pulse_w[0];
    dir_state_d = dir_state_q ^ pulse_w[1];
    tick_cnt_d  = '0;
    tick_d      = 1'b0;
    // A wrap on the same edge en_state falls still emits its tick; the
    // counter is cleared on that edge so it reads 0 whenever en_state is 0.
    if (en_state_q) begin
      tick_d = (tick_cnt_q == TICK_LAST);
      if (!tick_d && !pulse_w[0]) begin
        tick_cnt_d = tick_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_state_q  <= 1'b0;
      dir_state_q <= 1'b1;
      tick_cnt_q  <= '0;
      tick_q      <= 1'b0;
    end else begin
      en_state_q  <= en_state_d;
      dir_state_q <= dir_state_d;
      tick_cnt_q  <= tick_cnt_d;
      tick_q      <= tick_d;
    end
  end

  assign en_pulse   = pulse_w[0];
  assign dir_pulse  = pulse_w[1];
  assign en_state   = en_state_q;
  assign dir_state  = dir_state_q;
  assign count_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_ctrl
// Brief   : Self-checking bench for button_ctrl with an edge-history model
// Revision: 1.0
// ============================================================================
module tb_button_ctrl;

  localparam int DB   = 4;
  localparam int TK   = 5;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic dir = 1'b0;
  logic en_pulse, dir_pulse, en_state, dir_state, count_tick;
  logic [4:0] obs;

  assign obs = {en_pulse, dir_pulse, en_state, dir_state, count_tick};

  int checks = 0;
  int errors = 0;

  // Model state, indexed by edge number: value held after that edge.
  int k = 1;
  bit raw_h  [2][MAXE];
  bit db_h   [2][MAXE];
  bit pul_h  [2][MAXE];
  bit st_h   [2][MAXE];
  bit tick_h [MAXE];
  int last_flip [2];
  int rise_e = 0;

  button_ctrl #(
    .DB_CYCLES  (DB),
    .TICK_CYCLES(TK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dir       (dir),
    .en_pulse  (en_pulse),
    .dir_pulse (dir_pulse),
    .en_state  (en_state),
    .dir_state (dir_state),
    .count_tick(count_tick)
  );

  always #5 clk = ~clk;

  // Level accepted once the input seen through the two-stage delay has
  // differed from the current level on DB consecutive edges since the last
  // change; pulse one edge after a rise; toggle one edge after a pulse;
  // ticks every TK edges measured from the rise of en_state.
  function automatic void model_edge(input bit r, input bit e, input bit d);
    bit flip;
    k++;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        raw_h[c][k]  = 1'b0;
        db_h[c][k]   = 1'b0;
        pul_h[c][k]  = 1'b0;
        last_flip[c] = k;
      end
      st_h[0][k] = 1'b0;
      st_h[1][k] = 1'b1;
      tick_h[k]  = 1'b0;
    end else begin
      raw_h[0][k] = e;
      raw_h[1][k] = d;
      for (int c = 0; c < 2; c++) begin
        flip = (k - DB + 1 > last_flip[c]);
        if (flip) begin
          for (int j = 0; j < DB; j++) begin
            if (raw_h[c][k-j-2] == db_h[c][k-1]) flip = 1'b0;
          end
        end
        db_h[c][k] = flip ? ~db_h[c][k-1] : db_h[c][k-1];
        if (flip) last_flip[c] = k;
        pul_h[c][k] = db_h[c][k-1] & ~db_h[c][k-2];
        st_h[c][k]  = st_h[c][k-1] ^ pul_h[c][k-1];
      end
      if (st_h[0][k] && !st_h[0][k-1]) rise_e = k;
      tick_h[k] = st_h[0][k-1] && (((k - rise_e) % TK) == 0);
    end
  endfunction

  function automatic logic [4:0] exp_vec();
    return {pul_h[0][k], pul_h[1][k], st_h[0][k], st_h[1][k], tick_h[k]};
  endfunction

  task automatic step(input bit r, input bit e, input bit d);
    rst = r;
    en  = e;
    dir = d;
    @(posedge clk);
    model_edge(r, e, d);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== 5'b00010) begin
        errors++;
        $display("FAIL reset_vals edge %0d: got %b want %b", k, obs, 5'b00010);
      end
    end
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== 5'b00010) begin
        errors++;
        $display("FAIL idle_quiet edge %0d: got %b want %b", k, obs, 5'b00010);
      end
    end
  endtask

  task automatic test_en_press();
    logic [4:0] want;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0);
      want = {i == 6, 1'b0, i >= 7, 1'b1, (i >= 12) && (((i - 7) % 5) == 0)};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL en_press i=%0d: got %b want %b", i, obs, want);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL en_press_model edge %0d: got %b want %b", k, obs, exp_vec());
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL en_release edge %0d: got %b want %b", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, ((i / 2) % 2) == 0);
      checks++;
      if (dir_pulse !== 1'b0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL bounce edge %0d: got %b want %b", k, obs, exp_vec());
      end
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1);
      pulses += int'(dir_pulse);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL bounce_hold edge %0d: got %b want %b", k, obs, exp_vec());
      end
    end
    checks++;
    if (pulses != 1 || dir_state !== 1'b0) begin
      errors++;
      $display("FAIL bounce_result: got pulses=%0d dir_state=%b want pulses=1 dir_state=0",
               pulses, dir_state);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (en_pulse !== dir_pulse || obs !== exp_vec()) begin
        errors++;
        $display("FAIL simul edge %0d: got %b want %b", k, obs, exp_vec());
      end
    end
    checks++;
    if (en_state !== 1'b0 || dir_state !== 1'b1) begin
      errors++;
      $display("FAIL simul_states: got en=%b dir=%b want en=0 dir=1", en_state, dir_state);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_second_press();
    logic [1:0] want;
    // First press turns counting on, second turns it off.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 22; i++) begin
        step(1'b0, i < 10, 1'b0);
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL press%0d edge %0d: got %b want %b", p, k, obs, exp_vec());
        end
      end
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (en_state !== 1'b0 || count_tick !== 1'b0) begin
        errors++;
        $display("FAIL stopped i=%0d: got en_state=%b tick=%b want 0 0", i, en_state, count_tick);
      end
    end
    for (int i = 0; i < 22; i++) begin
      step(1'b0, i < 10, 1'b0);
      want = {i >= 7, (i >= 12) && (((i - 7) % 5) == 0)};
      checks++;
      if ({en_state, count_tick} !== want) begin
        errors++;
        $display("FAIL restart i=%0d: got %b want %b", i, {en_state, count_tick}, want);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== 5'b00010) begin
      errors++;
      $display("FAIL rst_override: got %b want %b", obs, 5'b00010);
    end
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if (en_pulse !== (i == 6) || obs !== exp_vec()) begin
        errors++;
        $display("FAIL rst_held i=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit e = 1'b0;
    bit d = 1'b0;
    bit r;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) e = ~e;
      if ($urandom_range(7) == 0) d = ~d;
      r = ($urandom_range(399) == 0);
      step(r, e, d);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random edge %0d: got %b want %b", k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_en_press();
    test_bounce();
    test_simultaneous();
    test_second_press();
    test_reset_mid_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
